// File: rtl/qam16_demapper_pkg.sv
// Shared types, constants and helpers for the 16QAM hard-decision demapper.
package qam16_demapper_pkg;

    localparam int DW = 18;
    localparam logic [DW-1:0] THR_INIT = 18'd16384;

    // Per-axis Gray codes: {sign bit, inner bit}
    localparam logic [1:0] GRAY_M3 = 2'b00;
    localparam logic [1:0] GRAY_M1 = 2'b01;
    localparam logic [1:0] GRAY_P1 = 2'b11;
    localparam logic [1:0] GRAY_P3 = 2'b10;

    typedef enum logic {
        SER_IDLE,
        SER_SHIFT
    } ser_state_t;

    // |x| as a DW-1 bit unsigned value; the most-negative code saturates
    // instead of wrapping to zero.
    function automatic logic [DW-2:0] mag_sat(input logic signed [DW-1:0] x);
        if (!x[DW-1])
            return x[DW-2:0];
        else if (x[DW-2:0] == '0)
            return '1;
        else
            return ~x[DW-2:0] + (DW-1)'(1);
    endfunction

    // Hard decision for one axis; a magnitude equal to the threshold is outer.
    function automatic logic [1:0] decide_axis(input logic signed [DW-1:0] x,
                                               input logic [DW-2:0] t);
        logic inner;
        inner = (mag_sat(x) < t);
        if (x[DW-1])
            return inner ? GRAY_M1 : GRAY_M3;
        else
            return inner ? GRAY_P1 : GRAY_P3;
    endfunction

endpackage

// File: rtl/qam16_demapper_if.sv
// Sample/symbol/bit-stream bundle between the timing-recovery path and the demapper.
interface qam16_demapper_if;
    import qam16_demapper_pkg::*;

    logic signed [DW-1:0] di;
    logic signed [DW-1:0] dq;
    logic                 sync;
    logic [3:0]           sym;
    logic                 sym_valid;
    logic                 bit_out;
    logic                 bit_valid;
    logic [DW-2:0]        thr;
    logic                 ovf;

    modport master (
        output di, dq, sync,
        input  sym, sym_valid, bit_out, bit_valid, thr, ovf
    );

    modport slave (
        input  di, dq, sync,
        output sym, sym_valid, bit_out, bit_valid, thr, ovf
    );

endinterface

// File: rtl/qam16_demapper_bit_serializer4.sv
// Turns 4-bit symbols into an MSB-first bit stream with a one-deep hold slot
// to absorb a symbol that arrives while the previous one is still shifting.
module bit_serializer4
    import qam16_demapper_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sym,
    input  logic       sym_valid,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       ovf
);

    ser_state_t state, state_nxt;
    logic [3:0] shreg, shreg_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [3:0] hold, hold_nxt;
    logic       full, full_nxt;
    logic       ovf_nxt, bit_out_nxt, bit_valid_nxt;
    logic       load_en;
    logic [3:0] load_src;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SER_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            hold      <= '0;
            full      <= 1'b0;
            ovf       <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            full      <= full_nxt;
            ovf       <= ovf_nxt;
            bit_out   <= bit_out_nxt;
            bit_valid <= bit_valid_nxt;
        end
    end

    // Next-state, shift and hold-slot control; cnt == 3 means the 4th bit is on bit_out
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        full_nxt      = full;
        ovf_nxt       = ovf;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = bit_valid;
        load_en       = 1'b0;
        load_src      = sym;

        case (state)
            SER_IDLE: begin
                if (sym_valid) begin
                    load_en  = 1'b1;
                    load_src = sym;
                end
            end
            SER_SHIFT: begin
                if (cnt == 2'd3) begin
                    if (full) begin
                        load_en  = 1'b1;
                        load_src = hold;
                        full_nxt = 1'b0;
                        if (sym_valid)
                            ovf_nxt = 1'b1;
                    end else if (sym_valid) begin
                        load_en  = 1'b1;
                        load_src = sym;
                    end else begin
                        state_nxt     = SER_IDLE;
                        bit_valid_nxt = 1'b0;
                        bit_out_nxt   = 1'b0;
                    end
                end else begin
                    bit_out_nxt = shreg[3];
                    shreg_nxt   = {shreg[2:0], 1'b0};
                    cnt_nxt     = cnt + 2'd1;
                    if (sym_valid) begin
                        if (full) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            hold_nxt = sym;
                            full_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = SER_IDLE;
        endcase

        if (load_en) begin
            state_nxt     = SER_SHIFT;
            bit_out_nxt   = load_src[3];
            bit_valid_nxt = 1'b1;
            shreg_nxt     = {load_src[2:0], 1'b0};
            cnt_nxt       = 2'd0;
        end
    end

endmodule

// File: rtl/qam16_demapper.sv
// 16QAM hard-decision demapper: adaptive inner/outer threshold, Gray decision
// per axis, and a serializer producing one bit per clock at full symbol rate.
module qam16_demapper #(
    parameter int                                     AVG_SH   = 6,
    parameter logic [qam16_demapper_pkg::DW-1:0]      THR_INIT = qam16_demapper_pkg::THR_INIT
) (
    input  logic              clk,
    input  logic              rst,
    qam16_demapper_if.slave   bus
);
    import qam16_demapper_pkg::*;

    localparam int AW = DW - 1 + AVG_SH;
    localparam logic [AW-1:0] ACC_INIT = {THR_INIT[DW-2:0], {AVG_SH{1'b0}}};

    logic [AW-1:0] acc;
    logic [AW:0]   acc_sum;
    logic [AW-1:0] acc_next;
    logic [DW-2:0] thr_r;
    logic [DW-2:0] mag_i, mag_q;
    logic [DW-1:0] half_sum;
    logic [3:0]    sym_r;
    logic          sym_valid_r;

    assign mag_i    = mag_sat(bus.di);
    assign mag_q    = mag_sat(bus.dq);
    assign half_sum = ({1'b0, mag_i} + {1'b0, mag_q}) >> 1;
    // The leak term never exceeds acc, so only the top end can overflow.
    assign acc_sum  = {1'b0, acc} + {{AVG_SH{1'b0}}, half_sum} - {1'b0, acc >> AVG_SH};
    assign acc_next = acc_sum[AW] ? '1 : acc_sum[AW-1:0];

    // Leaky average of the mean axis magnitude; the decision below sees the old threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= ACC_INIT;
            thr_r <= THR_INIT[DW-2:0];
        end else if (bus.sync) begin
            acc   <= acc_next;
            thr_r <= acc_next[AW-1:AVG_SH];
        end
    end

    // Registered hard decision; sym holds between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_r       <= '0;
            sym_valid_r <= 1'b0;
        end else begin
            sym_valid_r <= bus.sync;
            if (bus.sync)
                sym_r <= {decide_axis(bus.di, thr_r), decide_axis(bus.dq, thr_r)};
        end
    end

    bit_serializer4 u_ser (
        .clk       (clk),
        .rst       (rst),
        .sym       (sym_r),
        .sym_valid (sym_valid_r),
        .bit_out   (bus.bit_out),
        .bit_valid (bus.bit_valid),
        .ovf       (bus.ovf)
    );

    assign bus.sym       = sym_r;
    assign bus.sym_valid = sym_valid_r;
    assign bus.thr       = thr_r;

endmodule
